// File: rtl/section_coeff_selector_pkg.sv
// Shared constants, coefficient type and select-width helper for the
// double-buffered per-section coefficient selector.
package sec_coef_pkg;

    localparam int NUM_SECTIONS_DEF = 32'sd4;
    localparam int COEF_W_DEF       = 32'sd32;

    typedef logic [COEF_W_DEF-1:0] coef_t;

    // Index width for n entries; a single entry still needs one address bit.
    function automatic int sel_w(input int n);
        if (n <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/section_coeff_selector_if.sv
// Control/read bus of the coefficient selector: shadow writes, commit, section
// read request and the registered read/status outputs.
interface section_coeff_selector_if
    import sec_coef_pkg::*;
#(
    parameter int NUM_SECTIONS = NUM_SECTIONS_DEF,
    parameter int COEF_W       = COEF_W_DEF
);
    localparam int SEL_W = sel_w(NUM_SECTIONS);

    logic              wr_en;
    logic [SEL_W-1:0]  wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              commit;
    logic [SEL_W-1:0]  section;
    logic              section_valid;
    logic [COEF_W-1:0] coef_o;
    logic              coef_valid;
    logic              sel_err;
    logic              wr_err;
    logic              pending;

    modport master (
        output wr_en, wr_addr, wr_data, commit, section, section_valid,
        input  coef_o, coef_valid, sel_err, wr_err, pending
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, section, section_valid,
        output coef_o, coef_valid, sel_err, wr_err, pending
    );

endinterface

// File: rtl/coeff_dbuf_bank.sv
// Shadow/active coefficient storage with range-checked write decode, atomic
// shadow-to-active commit and a combinational read of the active bank.
module coeff_dbuf_bank
    import sec_coef_pkg::*;
#(
    parameter int NUM_SECTIONS = NUM_SECTIONS_DEF,
    parameter int COEF_W       = COEF_W_DEF,
    parameter int SEL_W        = sel_w(NUM_SECTIONS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              commit,
    input  logic [SEL_W-1:0]  rd_addr,
    output logic [COEF_W-1:0] rd_data,
    output logic              rd_in_range,
    output logic              wr_accept,
    output logic              wr_reject
);
    // One extra bit so NUM_SECTIONS itself is representable for power-of-two sizes.
    localparam logic [SEL_W:0] NUM_L = NUM_SECTIONS[SEL_W:0];

    logic [COEF_W-1:0] shadow_r [NUM_SECTIONS];
    logic [COEF_W-1:0] active_r [NUM_SECTIONS];
    logic              wr_in_range_s;

    assign wr_in_range_s = ({1'b0, wr_addr} < NUM_L);
    assign rd_in_range   = ({1'b0, rd_addr} < NUM_L);
    assign wr_accept     = wr_en & wr_in_range_s;
    assign wr_reject     = wr_en & ~wr_in_range_s;

    // Bank storage: commit copies pre-edge shadow, so a same-cycle write stays shadow-only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 32'sd0; i < NUM_SECTIONS; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
        end else begin
            if (commit) begin
                for (int i = 32'sd0; i < NUM_SECTIONS; i++) begin
                    active_r[i] <= shadow_r[i];
                end
            end
            if (wr_accept) begin
                shadow_r[wr_addr] <= wr_data;
            end
        end
    end

    // Active-bank read mux, zero for out-of-range sections.
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = active_r[rd_addr];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/section_coeff_selector.sv
// Registered per-section coefficient selector: double-buffered bank plus the
// output register, read/write error flags and uncommitted-write tracking.
module section_coeff_selector
    import sec_coef_pkg::*;
#(
    parameter int NUM_SECTIONS = NUM_SECTIONS_DEF,
    parameter int COEF_W       = COEF_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    section_coeff_selector_if.slave bus
);
    localparam int SEL_W = sel_w(NUM_SECTIONS);

    logic [COEF_W-1:0] rd_data_s;
    logic              rd_in_range_s;
    logic              wr_accept_s;
    logic              wr_reject_s;

    logic [COEF_W-1:0] coef_r;
    logic              coef_valid_r;
    logic              sel_err_r;
    logic              wr_err_r;
    logic              pending_r;

    coeff_dbuf_bank #(
        .NUM_SECTIONS (NUM_SECTIONS),
        .COEF_W       (COEF_W),
        .SEL_W        (SEL_W)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .commit      (bus.commit),
        .rd_addr     (bus.section),
        .rd_data     (rd_data_s),
        .rd_in_range (rd_in_range_s),
        .wr_accept   (wr_accept_s),
        .wr_reject   (wr_reject_s)
    );

    // Read output register; coef_o and sel_err hold while no request is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_r       <= '0;
            coef_valid_r <= 1'b0;
            sel_err_r    <= 1'b0;
        end else if (bus.section_valid) begin
            coef_r       <= rd_data_s;
            coef_valid_r <= 1'b1;
            sel_err_r    <= ~rd_in_range_s;
        end else begin
            coef_valid_r <= 1'b0;
        end
    end

    // Write status: one-cycle reject pulse and pending, where a new write outranks commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_r  <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            wr_err_r <= wr_reject_s;
            if (wr_accept_s) begin
                pending_r <= 1'b1;
            end else if (bus.commit) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign bus.coef_o     = coef_r;
    assign bus.coef_valid = coef_valid_r;
    assign bus.sel_err    = sel_err_r;
    assign bus.wr_err     = wr_err_r;
    assign bus.pending    = pending_r;

endmodule

// File: tb/tb_section_coeff_selector.sv
// Directed vector table for the selector corner cases, then randomized traffic
// against a behavioural model of the shadow/active banks.
module tb_section_coeff_selector;
    import sec_coef_pkg::*;

    localparam int N = 5;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    section_coeff_selector_if #(.NUM_SECTIONS(N), .COEF_W(W)) bus ();

    section_coeff_selector #(.NUM_SECTIONS(N), .COEF_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          we;
        logic [2:0]  wa;
        logic [31:0] wd;
        bit          cm;
        bit          sv;
        logic [2:0]  sec;
        logic [31:0] e_coef;
        bit          e_valid;
        bit          e_serr;
        bit          e_werr;
        bit          e_pend;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    // behavioural model state
    logic [31:0] m_shadow [N];
    logic [31:0] m_active [N];
    logic [31:0] m_coef;
    bit          m_valid, m_serr, m_werr, m_pend;

    function automatic vec_t mk(bit r, bit we, int wa, logic [31:0] wd, bit cm, bit sv, int sec,
                                logic [31:0] ec, bit ev, bit es, bit ew, bit ep);
        vec_t v;
        v.rst = r; v.we = we; v.wa = wa[2:0]; v.wd = wd; v.cm = cm;
        v.sv = sv; v.sec = sec[2:0];
        v.e_coef = ec; v.e_valid = ev; v.e_serr = es; v.e_werr = ew; v.e_pend = ep;
        return v;
    endfunction

    task automatic drive(bit r, bit we, logic [2:0] wa, logic [31:0] wd, bit cm, bit sv, logic [2:0] sec);
        rst               = r;
        bus.wr_en         = we;
        bus.wr_addr       = wa;
        bus.wr_data       = wd;
        bus.commit        = cm;
        bus.section_valid = sv;
        bus.section       = sec;
    endtask

    task automatic check(string tag, int idx, logic [31:0] ec, bit ev, bit es, bit ew, bit ep);
        tests += 5;
        if (bus.coef_o !== ec) begin
            fails++; $display("FAIL %s%0d coef_o got %h exp %h", tag, idx, bus.coef_o, ec);
        end
        if (bus.coef_valid !== ev) begin
            fails++; $display("FAIL %s%0d coef_valid got %b exp %b", tag, idx, bus.coef_valid, ev);
        end
        if (bus.sel_err !== es) begin
            fails++; $display("FAIL %s%0d sel_err got %b exp %b", tag, idx, bus.sel_err, es);
        end
        if (bus.wr_err !== ew) begin
            fails++; $display("FAIL %s%0d wr_err got %b exp %b", tag, idx, bus.wr_err, ew);
        end
        if (bus.pending !== ep) begin
            fails++; $display("FAIL %s%0d pending got %b exp %b", tag, idx, bus.pending, ep);
        end
    endtask

    // One clock of the specified behaviour: read and commit see pre-edge banks.
    task automatic model_step(bit r, bit we, int wa, logic [31:0] wd, bit cm, bit sv, int sec);
        logic [31:0] snap [N];
        if (r) begin
            for (int i = 0; i < N; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
            m_coef = '0; m_valid = 0; m_serr = 0; m_werr = 0; m_pend = 0;
            return;
        end
        if (sv) begin
            m_valid = 1;
            if (sec < N) begin m_coef = m_active[sec]; m_serr = 0; end
            else begin m_coef = '0; m_serr = 1; end
        end else begin
            m_valid = 0;
        end
        m_werr = we && (wa >= N);
        snap = m_shadow;
        if (cm) m_active = snap;
        if (we && wa < N) m_shadow[wa] = wd;
        if (we && wa < N) m_pend = 1;
        else if (cm) m_pend = 0;
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0);

        // reset and empty reads
        vecs.push_back(mk(1,0,0,0,0,0,0, 32'h0,0,0,0,0));
        for (int s = 0; s < 4; s++) vecs.push_back(mk(0,0,0,0,0,1,s, 32'h0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,0,0,0,0));
        // shadow writes are invisible to reads until commit
        vecs.push_back(mk(0,1,0,32'h11111111,0,1,0, 32'h0,1,0,0,1));
        vecs.push_back(mk(0,1,1,32'h22222222,0,1,1, 32'h0,1,0,0,1));
        vecs.push_back(mk(0,1,2,32'h33333333,0,1,2, 32'h0,1,0,0,1));
        vecs.push_back(mk(0,1,3,32'h44444444,0,1,3, 32'h0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0, 32'h0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,2, 32'h33333333,1,0,0,0));
        // commit plus same-cycle write
        vecs.push_back(mk(0,1,1,32'hDEADBEEF,1,0,0, 32'h33333333,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h22222222,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0, 32'h22222222,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'hDEADBEEF,1,0,0,0));
        // commit plus same-cycle read returns the old value
        vecs.push_back(mk(0,1,3,32'hAAAA0000,0,0,0, 32'hDEADBEEF,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,1,3, 32'h44444444,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,3, 32'hAAAA0000,1,0,0,0));
        // out-of-range write and read
        vecs.push_back(mk(0,1,6,32'h12345678,0,0,0, 32'hAAAA0000,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'hAAAA0000,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,7, 32'h0,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,4, 32'h0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,0, 32'h11111111,1,0,0,0));
        vecs.push_back(mk(0,1,5,32'h0BADF00D,0,1,5, 32'h0,1,1,1,0));
        vecs.push_back(mk(0,0,0,0,1,1,1, 32'hDEADBEEF,1,0,0,0));
        // last valid index
        vecs.push_back(mk(0,1,4,32'hCAFEF00D,0,0,0, 32'hDEADBEEF,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0, 32'hDEADBEEF,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,4, 32'hCAFEF00D,1,0,0,0));
        // reset overrides write, commit and read
        vecs.push_back(mk(0,1,0,32'h55555555,0,0,0, 32'hCAFEF00D,0,0,0,1));
        vecs.push_back(mk(1,1,1,32'h66666666,1,1,0, 32'h0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0, 32'h0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,3, 32'h0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 32'h0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0, 32'h0,1,0,0,0));

        @(negedge clk);
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].cm, vecs[k].sv, vecs[k].sec);
            @(posedge clk); #1;
            check("vec", k, vecs[k].e_coef, vecs[k].e_valid, vecs[k].e_serr, vecs[k].e_werr, vecs[k].e_pend);
        end

        // randomized phase, starting from a reset so the model is aligned
        for (int c = 0; c < 3000; c++) begin
            bit r, we, cm, sv;
            int wa, sec;
            logic [31:0] wd;
            r   = (c == 0) || ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 2) == 0);
            wa  = $urandom_range(0, 7);
            wd  = $urandom;
            cm  = ($urandom_range(0, 7) == 0);
            sv  = ($urandom_range(0, 1) == 1);
            sec = $urandom_range(0, 7);
            drive(r, we, wa[2:0], wd, cm, sv, sec[2:0]);
            model_step(r, we, wa, wd, cm, sv, sec);
            @(posedge clk); #1;
            check("rnd", c, m_coef, m_valid, m_serr, m_werr, m_pend);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
